// File: rtl/serial_lin_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and the
// default operand width.
package serial_lin_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_lin_adder_fa_cell.sv
// Single-bit full adder used by the serial adder, plus the shared 2-input XOR
// cell it is built from.
module xor2_cell (
    input  logic a,
    input  logic b,
    output logic y
);

    assign y = a ^ b;

endmodule

module serial_fa_cell (
    input  logic a_bit,
    input  logic b_bit,
    input  logic c_in,
    output logic s_bit,
    output logic c_out
);

    logic ab_x;

    // Sum is two cascaded XOR cells; the first stage output is reused by the carry.
    xor2_cell u_xor_ab (
        .a (a_bit),
        .b (b_bit),
        .y (ab_x)
    );

    xor2_cell u_xor_sc (
        .a (ab_x),
        .b (c_in),
        .y (s_bit)
    );

    assign c_out = (a_bit & b_bit) | (c_in & ab_x);

endmodule

// File: rtl/serial_lin_adder.sv
// Bit-serial adder: shifts two operands LSB-first through one full-adder cell,
// registering the carry and assembling the sum word over WIDTH cycles.
module serial_lin_adder
    import serial_lin_adder_pkg::*;
#(
    parameter  int WIDTH = DEFAULT_WIDTH,
    localparam int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    state_t             state_q;
    state_t             state_d;
    logic [WIDTH-1:0]   sa_q;
    logic [WIDTH-1:0]   sb_q;
    logic [WIDTH-2:0]   res_q;
    logic               carry_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   sum_q;
    logic               cout_q;

    logic               s_bit;
    logic               c_next;
    logic               last_bit;
    logic [WIDTH-1:0]   res_shift;

    serial_fa_cell u_fa (
        .a_bit (sa_q[0]),
        .b_bit (sb_q[0]),
        .c_in  (carry_q),
        .s_bit (s_bit),
        .c_out (c_next)
    );

    assign last_bit  = (cnt_q == CNT_W'(WIDTH - 1));
    // New bit enters at the MSB; after the final shift this is the whole sum.
    assign res_shift = {s_bit, res_q};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start)    state_d = ST_RUN;
            ST_RUN:  if (last_bit) state_d = ST_DONE;
            ST_DONE:               state_d = ST_IDLE;
            default:               state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sa_q    <= '0;
            sb_q    <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        sa_q    <= a;
                        sb_q    <= b;
                        carry_q <= cin;
                        cnt_q   <= '0;
                    end
                end
                ST_RUN: begin
                    sa_q    <= sa_q >> 1;
                    sb_q    <= sb_q >> 1;
                    carry_q <= c_next;
                    res_q   <= res_shift[WIDTH-1:1];
                    cnt_q   <= cnt_q + 1'b1;
                    // Outputs only ever see the completed word.
                    if (last_bit) begin
                        sum_q  <= res_shift;
                        cout_q <= c_next;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy = (state_q == ST_RUN);
    assign done = (state_q == ST_DONE);
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_lin_adder.sv
// Scoreboard bench for serial_lin_adder: stimulus pushes expected a+b+cin
// results with their due cycle; a monitor pops and checks on every done.
module tb_serial_lin_adder;
    import serial_lin_adder_pkg::*;

    localparam int WIDTH = DEFAULT_WIDTH;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    typedef struct {
        logic [WIDTH:0] res;
        int             due;
    } exp_t;

    exp_t exp_q[$];
    int   cyc   = 0;
    int   n_vec = 0;
    int   n_bad = 0;

    serial_lin_adder #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_output(input string name, input logic [WIDTH:0] act, input logic [WIDTH:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("[TB] FAIL %s: got %h, want %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every done must match the oldest expected result at its due cycle.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0 && exp_q[0].due < cyc) begin
            n_vec++;
            n_bad++;
            $display("[TB] FAIL missing_done: no done by cycle %0d, want %h", exp_q[0].due, exp_q[0].res);
            void'(exp_q.pop_front());
        end
        if (done === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("[TB] FAIL unexpected_done: got %h at cycle %0d, want none", {cout, sum}, cyc);
            end else begin
                e = exp_q.pop_front();
                check_output("result", {cout, sum}, e.res);
                n_vec++;
                if (cyc != e.due) begin
                    n_bad++;
                    $display("[TB] FAIL done_latency: got cycle %0d, want cycle %0d", cyc, e.due);
                end
            end
        end
    end

    function automatic logic [WIDTH:0] model_add(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic c);
        return {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, c};
    endfunction

    // Called at a negedge; returns at the negedge just after the accepting edge.
    task automatic apply_stimulus(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv, input logic cv, input bit expect_it);
        exp_t e;
        a     = av;
        b     = bv;
        cin   = cv;
        start = 1'b1;
        if (expect_it) begin
            e.res = model_add(av, bv, cv);
            e.due = cyc + 1 + WIDTH;
            exp_q.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
        a     = WIDTH'($urandom);
        b     = WIDTH'($urandom);
        cin   = 1'($urandom);
    endtask

    task automatic wait_idle();
        repeat (WIDTH + 1) @(negedge clk);
    endtask

    task automatic check_quiet(input string name);
        check_output({name, "_busy"}, (WIDTH+1)'(busy), '0);
        check_output({name, "_done"}, (WIDTH+1)'(done), '0);
        check_output({name, "_sum"},  {cout, sum},      '0);
    endtask

    initial begin
        exp_t e;
        int   n_ops;
        logic [2*WIDTH:0] v;

        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        cin   = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            check_quiet("reset_idle");
            @(negedge clk);
        end

        // Basic add with busy window checked cycle by cycle.
        apply_stimulus(WIDTH'(8'h05), WIDTH'(8'h03), 1'b0, 1'b1);
        for (int i = 0; i < WIDTH; i++) begin
            check_output("busy_run", (WIDTH+1)'(busy), (WIDTH+1)'(1));
            @(negedge clk);
        end
        check_output("busy_done", (WIDTH+1)'(busy), '0);
        @(negedge clk);

        apply_stimulus('1, '0, 1'b1, 1'b1);
        wait_idle();
        apply_stimulus('1, '1, 1'b1, 1'b1);
        wait_idle();

        // Start pulsed mid-run must be dropped.
        apply_stimulus(WIDTH'(8'h10), WIDTH'(8'h20), 1'b0, 1'b1);
        repeat (2) @(negedge clk);
        a     = WIDTH'(8'hAA);
        b     = WIDTH'(8'h55);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (WIDTH - 2) @(negedge clk);
        repeat (WIDTH + 3) @(negedge clk);

        // Reset in the middle of a run discards it.
        apply_stimulus(WIDTH'(8'h7F), WIDTH'(8'h01), 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_quiet("mid_reset");
        repeat (WIDTH + 2) @(negedge clk);
        check_quiet("after_reset");
        apply_stimulus(WIDTH'(8'h01), WIDTH'(8'h01), 1'b0, 1'b1);
        wait_idle();

        // Back-to-back with start held high.
        a     = WIDTH'(8'h12);
        b     = WIDTH'(8'h34);
        cin   = 1'b0;
        start = 1'b1;
        e.res = model_add(WIDTH'(8'h12), WIDTH'(8'h34), 1'b0);
        e.due = cyc + 1 + WIDTH;
        exp_q.push_back(e);
        e.res = model_add(WIDTH'(8'hF0), WIDTH'(8'h20), 1'b0);
        e.due = cyc + 2 * WIDTH + 3;
        exp_q.push_back(e);
        @(negedge clk);
        a = WIDTH'(8'hF0);
        b = WIDTH'(8'h20);
        repeat (WIDTH + 2) @(negedge clk);
        start = 1'b0;
        wait_idle();

        // Randomised (or exhaustive for small widths) operands with random gaps.
        n_ops = (WIDTH <= 4) ? (1 << (2 * WIDTH + 1)) : 60;
        for (int i = 0; i < n_ops; i++) begin
            if (WIDTH <= 4) begin
                v = (2*WIDTH+1)'(i);
            end else begin
                v = {1'($urandom), WIDTH'($urandom), WIDTH'($urandom)};
            end
            apply_stimulus(v[WIDTH-1:0], v[2*WIDTH-1:WIDTH], v[2*WIDTH], 1'b1);
            wait_idle();
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        repeat (WIDTH + 4) @(negedge clk);
        check_output("queue_drained", (WIDTH+1)'(exp_q.size()), '0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, want completion");
        n_bad++;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/serial_lin_adder.md
Name: serial_lin_adder

Overview:
- Bit-serial adder that sequences two WIDTH-bit operands LSB-first through a single full-adder cell.
- The full-adder cell computes its sum bit as two cascaded 2-input XORs using the team's existing XOR cell; its carry bit is majority logic.
- This block is the stage directly upstream of the XOR cell. It feeds the XOR cell one bit pair per clock, registers the carry, and assembles the sum word.
- Load/start/done handshake to the controller above.

Parameters:
- WIDTH, 8, operand and sum width in bits; legal range 2..32.
- CNT_W, $clog2(WIDTH)+1, bit-counter width; derived, not overridden.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request to load operands; sampled only in IDLE.
- a  in  WIDTH  operand A; captured on the accepted start.
- b  in  WIDTH  operand B; captured on the accepted start.
- cin  in  1  carry-in; captured on the accepted start.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse when the result is valid.
- sum  out  WIDTH  result word; held stable from done until the next accepted start.
- cout  out  1  final carry; held with sum.

Behaviour:
- Reset: synchronous. If rst=1 at a rising edge, the next state is IDLE and:
  - busy=0, done=0, sum=0, cout=0;
  - shift registers and carry are cleared;
  - bit counter is 0.
- rst has priority over every other input, including in the middle of RUN. A partially computed operation is discarded and no done is produced.
- States: IDLE, RUN, DONE. Encoding: 2-bit constants in the shared package.
- IDLE:
  - start=1 → load sa<=a, sb<=b, carry<=cin, cnt<=0; go to RUN.
  - start=0 → stay in IDLE. sum/cout hold their previous values.
- RUN, each cycle:
  - s_bit = sa[0] ^ sb[0] ^ carry;
  - carry <= majority(sa[0], sb[0], carry);
  - sa, sb shift right by 1 with zero fill;
  - the result shift register shifts right with s_bit inserted at the MSB;
  - cnt <= cnt+1.
  - When cnt == WIDTH-1, this cycle processes the final bit; go to DONE.
- DONE, for exactly one cycle:
  - done=1, busy=0;
  - sum = assembled result; cout = final carry;
  - go to IDLE.
- Latency: start accepted at edge N → busy high for cycles N+1..N+WIDTH → done high during cycle N+WIDTH+1. Total WIDTH+1 cycles from start to done.
- start while busy or in DONE: ignored, with no queuing. The operands driven at that time are never captured.
- start held high continuously: a new operation is accepted on every IDLE cycle. Back-to-back throughput is one result per WIDTH+2 cycles.
- Arithmetic: unsigned. {cout, sum} = a + b + cin exactly, so full WIDTH+1-bit wrap is represented.
  - Example: a=2^WIDTH-1, b=0, cin=1 gives sum=0, cout=1.
- sum/cout update only on entry to DONE. They are never driven with partial results.
- The a, b and cin inputs may change freely after the accepted start.

Decomposition:
- Package serial_lin_adder_pkg holds:
  - state constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2;
  - the default WIDTH constant.
- One sub-module, serial_fa_cell:
  - combinational;
  - ports a_bit, b_bit, c_in, s_bit, c_out;
  - sum built from two instances of the team's 2-input XOR cell; carry as (a&b)|(c&(a^b)).
- The top level holds the FSM, counter, shift registers and carry flop.

Test Plan:
- Reset then idle: assert rst for 2 cycles, start=0 for 10 cycles → busy=0, done=0, sum=8'h00, cout=0 throughout.
- Basic add: a=8'h05, b=8'h03, cin=0, start pulse → busy high for 8 cycles; done pulse 9 cycles after start with sum=8'h08, cout=0.
- Full carry ripple: a=8'hFF, b=8'h00, cin=1 → sum=8'h00, cout=1. Then a=8'hFF, b=8'hFF, cin=1 → sum=8'hFF, cout=1.
- start ignored while busy:
  - start with a=8'h10, b=8'h20;
  - at cycle 3 pulse start with a=8'hAA, b=8'h55;
  - → exactly one done, sum=8'h30; no second done.
- Reset mid-operation: start a=8'h7F, b=8'h01; assert rst at cycle 4 → busy=0 next cycle, no done, sum=8'h00, cout=0. A following start a=8'h01, b=8'h01 gives sum=8'h02.
- Back-to-back with start held high: two operations, (8'h12 + 8'h34) then (8'hF0 + 8'h20) → done pulses 10 cycles apart, with sum=8'h46, cout=0 and then sum=8'h10, cout=1. The WIDTH=4 build passes the same exhaustive check of all 512 a/b/cin combinations against a+b+cin.
